cic_decim_ctrl: RTL and testbench
=================================

Name: cic_decim_ctrl

Overview:
Sequencer for the CIC integrator stage. Owns the integrator's oversampling select and safely changes ratio through a clear/flush sequence. Generates the decimation strobe that drives the integrator's clk_div-domain capture, and presents decimated samples on a valid/ready interface. Monitors the integrator truncation flags and keeps saturation and overrun status for the register block.

Parameters:
ODW, 23, integrator output data width
FLUSH_CYC, 8, cycles the integrator is held cleared (os_sel=000) on a ratio change; range 1..255
SATW, 8, width of the saturation event counter

Ports:
clk  in  1  single block clock, rising edge
reset_n  in  1  asynchronous active-low reset
cfg_os_sel  in  3  requested ratio: 000 bypass, 001..110 = 2^1..2^6
cfg_valid  in  1  one-cycle request to apply cfg_os_sel
cfg_busy  out  1  high while flushing
cfg_err  out  1  sticky: request with cfg_os_sel=111 seen
int_os_sel  out  3  drives integrator os_sel
dec_stb  out  1  one-cycle decimation strobe (clk_div equivalent)
int_data  in  ODW  integrator data_out
int_flag_t  in  2  integrator flag_t: [0] toggles per truncation, [1] sign
out_valid  out  1  decimated sample valid
out_ready  in  1  downstream accept
out_data  out  ODW  decimated sample
sat_cnt  out  SATW  saturating count of truncation events
sat_sign  out  1  sign of the most recent truncation event (1 = negative)
overrun  out  1  sticky: sample lost because out_valid was not accepted
clr_status  in  1  clears sat_cnt, sat_sign, overrun, cfg_err

Behaviour:
- Reset: state BYPASS, int_os_sel=000, dec_stb=0, out_valid=0, out_data=0, cfg_busy=0, cfg_err=0, sat_cnt=0, sat_sign=0, overrun=0, phase=0, flag_ref=0.
- States:
  - BYPASS: int_os_sel=000; dec_stb=1 every cycle.
  - FLUSH: int_os_sel=000; dec_stb=0; cfg_busy=1; flush counter runs 0..FLUSH_CYC-1.
  - RUN: int_os_sel=target; phase counter runs 0..2^N-1 and wraps; dec_stb=1 exactly when phase==2^N-1.
- Ratio change:
  - cfg_valid with 001..110: from any state, load target, clear the flush counter, go to FLUSH. cfg_valid during FLUSH restarts the flush with the new target.
  - After FLUSH_CYC cycles in FLUSH: go to RUN with phase=0. The first dec_stb occurs 2^N cycles after entering RUN.
  - cfg_valid with 000: go to BYPASS immediately, no flush.
  - cfg_valid with 111: ignored (state unchanged); set cfg_err.
- Output:
  - On a dec_stb cycle, out_data <= int_data and out_valid <= 1 at the next edge (1-cycle latency).
  - out_valid clears on out_valid&&out_ready with no simultaneous capture.
  - Capture while out_valid=1 and out_ready=0: overwrite out_data, set overrun.
  - Capture in the same cycle as an accepted handshake: out_valid stays 1, no overrun.
  - Entering FLUSH clears out_valid; a pending sample is discarded without setting overrun.
- Flag monitor:
  - Sample int_flag_t only on dec_stb cycles.
  - If int_flag_t[0] != flag_ref: truncation event. sat_cnt increments, saturating at 2^SATW-1; sat_sign <= int_flag_t[1].
  - flag_ref <= int_flag_t[0] on every dec_stb, and on the FLUSH->RUN transition (resync, never counted as an event).
- clr_status: clears the status bits on the next edge. If an event occurs in the same cycle, the event wins: sat_cnt=1, overrun=1 as applicable.
- Reset asserted mid-operation: all state returns to reset values immediately, asynchronously.

Test Plan:
- Reset, then cfg_os_sel=011 with cfg_valid -> cfg_busy=1 and int_os_sel=000 for 8 cycles; int_os_sel=011; dec_stb first high 8 cycles later, then every 8 cycles; out_data equals int_data at each strobe; out_valid follows 1 cycle later.
- RUN at ratio 4 with out_ready=0 across 2 strobes -> out_data holds the second sample, overrun=1; clr_status -> overrun=0.
- RUN at ratio 2, toggle int_flag_t[0] with [1]=1 before 3 strobes -> sat_cnt=3, sat_sign=1; 300 toggles -> sat_cnt=255 and holds.
- cfg_valid 101 at flush cycle 5, then cfg_valid 111 -> flush restarts (8 fresh cycles); target stays 101; cfg_err=1.
- cfg_valid 000 while in RUN -> BYPASS next cycle; dec_stb every cycle; pending out_valid=1 with out_ready=1 each cycle -> out_valid stays 1, no overrun.
- Assert reset_n low mid-flush -> all outputs at reset values with no clock edge; int_os_sel=000.

Source files
------------

// File: rtl/cic_decim_ctrl.sv
// CIC integrator sequencer: owns the integrator ratio select, runs a
// clear/flush sequence on ratio changes, generates the decimation strobe,
// presents decimated samples on valid/ready and keeps truncation/overrun
// status for the register block.
module cic_decim_ctrl #(
  parameter int ODW       = 23,
  parameter int FLUSH_CYC = 8,
  parameter int SATW      = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [2:0]      cfg_os_sel,
  input  logic            cfg_valid,
  output logic            cfg_busy,
  output logic            cfg_err,
  output logic [2:0]      int_os_sel,
  output logic            dec_stb,
  input  logic [ODW-1:0]  int_data,
  input  logic [1:0]      int_flag_t,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ODW-1:0]  out_data,
  output logic [SATW-1:0] sat_cnt,
  output logic            sat_sign,
  output logic            overrun,
  input  logic            clr_status
);

  typedef enum logic [1:0] {
    ST_BYPASS = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  localparam logic [7:0]      FLUSH_LAST = 8'(FLUSH_CYC - 1);
  localparam logic [SATW-1:0] SAT_MAX    = {SATW{1'b1}};
  localparam logic [SATW-1:0] SAT_ONE    = {{(SATW-1){1'b0}}, 1'b1};

  // Last phase value of a 2^n decimation period.
  function automatic logic [5:0] phase_last(input logic [2:0] n);
    phase_last = 6'((7'd1 << n) - 7'd1);
  endfunction

  state_t          state_q, state_d;
  logic [2:0]      target_q, target_d;
  logic [7:0]      flush_cnt_q, flush_cnt_d;
  logic [5:0]      phase_q, phase_d;
  logic            flag_ref_q, flag_ref_d;
  logic [2:0]      int_os_sel_q, int_os_sel_d;
  logic            dec_stb_q, dec_stb_d;
  logic            cfg_busy_q, cfg_busy_d;
  logic            cfg_err_q, cfg_err_d;
  logic            out_valid_q, out_valid_d;
  logic [ODW-1:0]  out_data_q, out_data_d;
  logic [SATW-1:0] sat_cnt_q, sat_cnt_d;
  logic            sat_sign_q, sat_sign_d;
  logic            overrun_q, overrun_d;

  logic go_flush_s, go_bypass_s, cfg_bad_s;
  logic resync_s, ovr_evt_s, trunc_evt_s;

  // Next-state logic for the sequencer, output capture and status.
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    flush_cnt_d  = flush_cnt_q;
    phase_d      = phase_q;
    flag_ref_d   = flag_ref_q;
    cfg_err_d    = cfg_err_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    sat_cnt_d    = sat_cnt_q;
    sat_sign_d   = sat_sign_q;
    overrun_d    = overrun_q;
    resync_s     = 1'b0;
    ovr_evt_s    = 1'b0;

    go_flush_s  = cfg_valid && (cfg_os_sel != 3'b000) && (cfg_os_sel != 3'b111);
    go_bypass_s = cfg_valid && (cfg_os_sel == 3'b000);
    cfg_bad_s   = cfg_valid && (cfg_os_sel == 3'b111);

    // Sequencer: ratio requests override whatever the FSM is doing.
    if (go_flush_s) begin
      state_d     = ST_FLUSH;
      target_d    = cfg_os_sel;
      flush_cnt_d = 8'd0;
      phase_d     = 6'd0;
    end else if (go_bypass_s) begin
      state_d = ST_BYPASS;
      phase_d = 6'd0;
    end else begin
      case (state_q)
        ST_BYPASS: begin
          phase_d = 6'd0;
        end
        ST_FLUSH: begin
          if (flush_cnt_q == FLUSH_LAST) begin
            state_d  = ST_RUN;
            phase_d  = 6'd0;
            resync_s = 1'b1;
          end else begin
            flush_cnt_d = flush_cnt_q + 8'd1;
          end
        end
        ST_RUN: begin
          if (phase_q == phase_last(target_q)) begin
            phase_d = 6'd0;
          end else begin
            phase_d = phase_q + 6'd1;
          end
        end
        default: begin
          state_d = ST_BYPASS;
          phase_d = 6'd0;
        end
      endcase
    end

    // Outputs are registered, so they are computed from the next state.
    int_os_sel_d = (state_d == ST_RUN) ? target_d : 3'b000;
    cfg_busy_d   = (state_d == ST_FLUSH);
    dec_stb_d    = (state_d == ST_BYPASS) ||
                   ((state_d == ST_RUN) && (phase_d == phase_last(target_d)));

    // Sample capture; a flush discards any pending sample silently.
    if (go_flush_s) begin
      out_valid_d = 1'b0;
    end else if (dec_stb_q) begin
      out_data_d  = int_data;
      out_valid_d = 1'b1;
      ovr_evt_s   = out_valid_q && !out_ready;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    // Truncation flag toggles are compared only on strobe cycles.
    trunc_evt_s = dec_stb_q && (int_flag_t[0] != flag_ref_q);
    if (dec_stb_q || resync_s) begin
      flag_ref_d = int_flag_t[0];
    end else begin
      flag_ref_d = flag_ref_q;
    end

    // Status: clear first, then let same-cycle events win.
    if (clr_status) begin
      sat_cnt_d  = {SATW{1'b0}};
      sat_sign_d = 1'b0;
      overrun_d  = 1'b0;
      cfg_err_d  = 1'b0;
    end else begin
      sat_cnt_d  = sat_cnt_q;
    end
    if (trunc_evt_s) begin
      sat_sign_d = int_flag_t[1];
      if (clr_status) begin
        sat_cnt_d = SAT_ONE;
      end else if (sat_cnt_q == SAT_MAX) begin
        sat_cnt_d = SAT_MAX;
      end else begin
        sat_cnt_d = sat_cnt_q + SAT_ONE;
      end
    end else begin
      sat_sign_d = sat_sign_d;
    end
    if (ovr_evt_s) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_d;
    end
    if (cfg_bad_s) begin
      cfg_err_d = 1'b1;
    end else begin
      cfg_err_d = cfg_err_d;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_BYPASS;
      target_q     <= 3'b000;
      flush_cnt_q  <= 8'd0;
      phase_q      <= 6'd0;
      flag_ref_q   <= 1'b0;
      int_os_sel_q <= 3'b000;
      dec_stb_q    <= 1'b0;
      cfg_busy_q   <= 1'b0;
      cfg_err_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= {ODW{1'b0}};
      sat_cnt_q    <= {SATW{1'b0}};
      sat_sign_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      flush_cnt_q  <= flush_cnt_d;
      phase_q      <= phase_d;
      flag_ref_q   <= flag_ref_d;
      int_os_sel_q <= int_os_sel_d;
      dec_stb_q    <= dec_stb_d;
      cfg_busy_q   <= cfg_busy_d;
      cfg_err_q    <= cfg_err_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      sat_cnt_q    <= sat_cnt_d;
      sat_sign_q   <= sat_sign_d;
      overrun_q    <= overrun_d;
    end
  end

  assign int_os_sel = int_os_sel_q;
  assign dec_stb    = dec_stb_q;
  assign cfg_busy   = cfg_busy_q;
  assign cfg_err    = cfg_err_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign sat_cnt    = sat_cnt_q;
  assign sat_sign   = sat_sign_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Directed bench for cic_decim_ctrl: flush sequencing, strobe timing,
// capture/overrun, truncation counting and asynchronous reset.
module tb_cic_decim_ctrl;

  logic        clk;
  logic        reset_n;
  logic [2:0]  cfg_os_sel;
  logic        cfg_valid;
  logic        cfg_busy;
  logic        cfg_err;
  logic [2:0]  int_os_sel;
  logic        dec_stb;
  logic [22:0] int_data;
  logic [1:0]  int_flag_t;
  logic        out_valid;
  logic        out_ready;
  logic [22:0] out_data;
  logic [7:0]  sat_cnt;
  logic        sat_sign;
  logic        overrun;
  logic        clr_status;

  int errors = 0;
  int checks = 0;

  cic_decim_ctrl #(.ODW(23), .FLUSH_CYC(8), .SATW(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_os_sel(cfg_os_sel), .cfg_valid(cfg_valid),
    .cfg_busy(cfg_busy), .cfg_err(cfg_err),
    .int_os_sel(int_os_sel), .dec_stb(dec_stb),
    .int_data(int_data), .int_flag_t(int_flag_t),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sat_cnt(sat_cnt), .sat_sign(sat_sign), .overrun(overrun),
    .clr_status(clr_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until dec_stb is high (bounded); returns ticks taken.
  task automatic wait_stb(output int n);
    n = 0;
    while (dec_stb !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("stb_seen", {31'd0, dec_stb}, 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_os_sel"}, {29'd0, int_os_sel}, 32'd0);
    check({tag, "_dec_stb"}, {31'd0, dec_stb}, 32'd0);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_out_data"}, {9'd0, out_data}, 32'd0);
    check({tag, "_busy"}, {31'd0, cfg_busy}, 32'd0);
    check({tag, "_err"}, {31'd0, cfg_err}, 32'd0);
    check({tag, "_sat_cnt"}, {24'd0, sat_cnt}, 32'd0);
    check({tag, "_sat_sign"}, {31'd0, sat_sign}, 32'd0);
    check({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
  endtask

  initial begin
    int n;
    logic fb;
    logic [22:0] d;

    reset_n    = 1'b0;
    cfg_os_sel = 3'b000;
    cfg_valid  = 1'b0;
    int_data   = 23'd0;
    int_flag_t = 2'b00;
    out_ready  = 1'b1;
    clr_status = 1'b0;
    fb         = 1'b0;

    // Reset values
    #1;
    check_reset_vals("rst");
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("byp_stb", {31'd0, dec_stb}, 32'd1);
    check("byp_valid0", {31'd0, out_valid}, 32'd0);

    // Ratio 8: flush 8 cycles, then strobes every 8 cycles
    cfg_os_sel = 3'b011;
    cfg_valid  = 1'b1;
    tick();
    cfg_valid  = 1'b0;
    check("fl_valid_clr", {31'd0, out_valid}, 32'd0);
    check("fl_stb0", {31'd0, dec_stb}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      check("fl_busy", {31'd0, cfg_busy}, 32'd1);
      check("fl_os_sel", {29'd0, int_os_sel}, 32'd0);
      tick();
    end
    check("run_busy", {31'd0, cfg_busy}, 32'd0);
    check("run_os_sel", {29'd0, int_os_sel}, 32'd3);
    check("run_ph0_stb", {31'd0, dec_stb}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      wait_stb(n);
      check("r8_period", n, 32'd7);
      check("r8_valid_pre", {31'd0, out_valid}, 32'd0);
      d = 23'h100000 + 23'(k * 23'h1111);
      int_data = d;
      tick();
      check("r8_valid", {31'd0, out_valid}, 32'd1);
      check("r8_data", {9'd0, out_data}, {9'd0, d});
    end

    // Ratio 4 with out_ready low across two strobes -> overrun
    out_ready  = 1'b0;
    cfg_os_sel = 3'b010;
    cfg_valid  = 1'b1;
    tick();
    cfg_valid  = 1'b0;
    wait_stb(n);
    check("r4_first", n, 32'd11);
    int_data = 23'h0AAAAA;
    tick();
    check("r4_valid1", {31'd0, out_valid}, 32'd1);
    check("r4_ovr0", {31'd0, overrun}, 32'd0);
    wait_stb(n);
    check("r4_period", n, 32'd3);
    int_data = 23'h055555;
    tick();
    check("r4_data2", {9'd0, out_data}, 32'h055555);
    check("r4_ovr1", {31'd0, overrun}, 32'd1);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("r4_ovr_clr", {31'd0, overrun}, 32'd0);
    check("r4_valid_hold", {31'd0, out_valid}, 32'd1);

    // Ratio 2 truncation monitor
    out_ready  = 1'b1;
    cfg_os_sel = 3'b001;
    cfg_valid  = 1'b1;
    tick();
    cfg_valid  = 1'b0;
    check("r2_flush_drop", {31'd0, out_valid}, 32'd0);
    wait_stb(n);
    check("r2_first", n, 32'd9);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) wait_stb(n);
      fb = ~fb;
      int_flag_t = {1'b1, fb};
      tick();
    end
    check("sat3", {24'd0, sat_cnt}, 32'd3);
    check("sat3_sign", {31'd0, sat_sign}, 32'd1);
    for (int i = 0; i < 300; i++) begin
      wait_stb(n);
      fb = ~fb;
      int_flag_t = {1'b1, fb};
      tick();
    end
    check("sat_max", {24'd0, sat_cnt}, 32'd255);
    wait_stb(n);
    fb = ~fb;
    int_flag_t = {1'b0, fb};
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("clr_evt_cnt", {24'd0, sat_cnt}, 32'd1);
    check("clr_evt_sign", {31'd0, sat_sign}, 32'd0);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("clr_cnt", {24'd0, sat_cnt}, 32'd0);
    check("r2_ovr", {31'd0, overrun}, 32'd0);

    // Restarted flush and illegal request
    cfg_os_sel = 3'b100;
    cfg_valid  = 1'b1;
    tick();
    cfg_valid  = 1'b0;
    repeat (5) tick();
    cfg_os_sel = 3'b101;
    cfg_valid  = 1'b1;
    tick();
    cfg_os_sel = 3'b111;
    tick();
    cfg_valid  = 1'b0;
    check("bad_err", {31'd0, cfg_err}, 32'd1);
    check("bad_busy", {31'd0, cfg_busy}, 32'd1);
    wait_stb(n);
    check("restart_len", n, 32'd38);
    check("r32_os_sel", {29'd0, int_os_sel}, 32'd5);

    // Back to bypass from RUN with a sample pending
    int_data   = 23'h012345;
    cfg_os_sel = 3'b000;
    cfg_valid  = 1'b1;
    tick();
    cfg_valid  = 1'b0;
    check("byp_os_sel", {29'd0, int_os_sel}, 32'd0);
    check("byp_stb1", {31'd0, dec_stb}, 32'd1);
    check("byp_valid", {31'd0, out_valid}, 32'd1);
    check("byp_data0", {9'd0, out_data}, 32'h012345);
    for (int i = 1; i < 5; i++) begin
      d = 23'h020000 + 23'(i);
      int_data = d;
      tick();
      check("byp_stb_n", {31'd0, dec_stb}, 32'd1);
      check("byp_valid_n", {31'd0, out_valid}, 32'd1);
      check("byp_data_n", {9'd0, out_data}, {9'd0, d});
      check("byp_ovr", {31'd0, overrun}, 32'd0);
    end
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("err_clr", {31'd0, cfg_err}, 32'd0);

    // Asynchronous reset mid-flush
    cfg_os_sel = 3'b011;
    cfg_valid  = 1'b1;
    tick();
    cfg_os_sel = 3'b111;
    tick();
    cfg_valid  = 1'b0;
    check("pre_rst_err", {31'd0, cfg_err}, 32'd1);
    check("pre_rst_busy", {31'd0, cfg_busy}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals("arst");
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
